// File: rtl/cpu_param.sv
// rtl/cpu_param.sv - parametrised multi-cycle core with loadable imem, FETCH/EXEC/MEM FSM
module cpu_param #(
    parameter int DW = 8,
    parameter int AW = 4,
    parameter int RN = 2,
    parameter int IW = 3 + 3 * RN + DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          imem_we,
    input  logic [AW-1:0] imem_waddr,
    input  logic [IW-1:0] imem_wdata,
    input  logic [RN-1:0] dbg_rsel,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          retire,
    output logic [15:0]   retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    localparam logic [2:0] OP_LDI   = 3'd0;
    localparam logic [2:0] OP_MOVPC = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_BZ    = 3'd3;
    localparam logic [2:0] OP_LD    = 3'd4;
    localparam logic [2:0] OP_ST    = 3'd5;
    localparam logic [2:0] OP_SUB   = 3'd6;

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   regs_q [2**RN];
    logic [DW-1:0]   regs_d [2**RN];
    logic            retire_q, retire_d;
    logic [15:0]     retire_cnt_q, retire_cnt_d;

    logic [IW-1:0]   imem [2**AW];
    logic [DW-1:0]   dmem [2**AW];
    logic [IW-1:0]   ir_q;
    logic [DW-1:0]   ld_data_q;

    logic [2:0]      op;
    logic [RN-1:0]   rd, ra, rb;
    logic [DW-1:0]   imm, ra_val, rb_val;
    logic [AW-1:0]   pc_inc;
    logic            imem_wr_en, dmem_wr_en;

    assign op     = ir_q[2:0];
    assign rd     = ir_q[3 +: RN];
    assign ra     = ir_q[3 + RN +: RN];
    assign rb     = ir_q[3 + 2 * RN +: RN];
    assign imm    = ir_q[IW-1 : 3 + 3 * RN];
    assign ra_val = regs_q[ra];
    assign rb_val = regs_q[rb];
    assign pc_inc = pc_q + AW'(1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        regs_d       = regs_q;
        retire_d     = 1'b0;
        retire_cnt_d = retire_cnt_q;
        imem_wr_en   = 1'b0;
        dmem_wr_en   = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                imem_wr_en = imem_we;
                if (start) begin
                    state_d      = S_FETCH;
                    pc_d         = '0;
                    retire_cnt_d = '0;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d  = S_FETCH;
                retire_d = 1'b1;
                pc_d     = pc_inc;
                case (op)
                    OP_LDI:   regs_d[rd] = imm;
                    OP_MOVPC: regs_d[rd] = DW'(pc_q);
                    OP_ADD:   regs_d[rd] = ra_val + rb_val;
                    OP_BZ:    if (ra_val == '0) pc_d = rb_val[AW-1:0];
                    OP_LD: begin
                        state_d  = S_MEM;
                        retire_d = 1'b0;
                        pc_d     = pc_q;
                    end
                    OP_ST:    dmem_wr_en = 1'b1;
                    OP_SUB:   regs_d[rd] = ra_val - rb_val;
                    default: begin
                        state_d = S_HALTED;
                        pc_d    = pc_q;
                    end
                endcase
            end
            S_MEM: begin
                regs_d[rd] = ld_data_q;
                pc_d       = pc_inc;
                retire_d   = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
        if (retire_d) retire_cnt_d = retire_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            regs_q       <= '{default: '0};
            retire_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            regs_q       <= regs_d;
            retire_q     <= retire_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Memories are not reset; reset only suppresses their writes.
    always_ff @(posedge clk) begin
        if (imem_wr_en && !rst_n) imem[imem_waddr] <= imem_wdata;
        if (dmem_wr_en && !rst_n) dmem[ra_val[AW-1:0]] <= rb_val;
        if (state_q == S_FETCH) ir_q <= imem[pc_q];
        if (state_q == S_EXEC) ld_data_q <= dmem[rb_val[AW-1:0]];
    end

    assign dbg_rdata  = regs_q[dbg_rsel];
    assign pc         = pc_q;
    assign busy       = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_MEM);
    assign halted     = (state_q == S_HALTED);
    assign retire     = retire_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_cpu_param.sv
// tb/tb_cpu_param.sv - directed and random programs checked against an ISA-level model
module tb_cpu_param;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_we;
    logic [3:0]  imem_waddr;
    logic [16:0] imem_wdata;
    logic [1:0]  dbg_rsel;
    logic [7:0]  dbg_rdata;
    logic [3:0]  pc;
    logic        busy, halted, retire;
    logic [15:0] retire_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int last_cyc;

    logic [16:0] prog [16];
    logic [7:0]  ref_regs [4];
    logic [7:0]  ref_dmem [16];

    cpu_param dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .dbg_rsel(dbg_rsel),
        .dbg_rdata(dbg_rdata), .pc(pc), .busy(busy), .halted(halted),
        .retire(retire), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] enc(input int op, input int rd, input int ra,
                                        input int rb, input int imm);
        return {imm[7:0], rb[1:0], ra[1:0], rd[1:0], op[2:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input int r, input logic [7:0] exp);
        dbg_rsel = 2'(r);
        #1;
        chk($sformatf("reg_r%0d", r), {24'd0, dbg_rdata}, {24'd0, exp});
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) prog[i] = enc(7, 0, 0, 0, 0);
    endtask

    // Instruction-level interpreter: architectural effects plus cycle/retire totals.
    task automatic model_run(output int cyc, output int ret, output int fpc, output bit ok);
        int p, op, rd, ra, rb;
        logic [16:0] w;
        logic [7:0]  a, b, imm;
        p = 0; cyc = 0; ret = 0; fpc = 0; ok = 0;
        for (int s = 0; s < 400 && !ok; s++) begin
            w   = prog[p];
            op  = int'(w[2:0]);
            rd  = int'(w[4:3]);
            ra  = int'(w[6:5]);
            rb  = int'(w[8:7]);
            imm = w[16:9];
            a   = ref_regs[ra];
            b   = ref_regs[rb];
            ret++;
            cyc += 2;
            case (op)
                0: begin ref_regs[rd] = imm;               p = (p + 1) % 16; end
                1: begin ref_regs[rd] = 8'(p);             p = (p + 1) % 16; end
                2: begin ref_regs[rd] = a + b;             p = (p + 1) % 16; end
                3: p = (a == 8'd0) ? int'(b[3:0]) : (p + 1) % 16;
                4: begin ref_regs[rd] = ref_dmem[b[3:0]];  p = (p + 1) % 16; cyc += 1; end
                5: begin ref_dmem[a[3:0]] = b;             p = (p + 1) % 16; end
                6: begin ref_regs[rd] = a - b;             p = (p + 1) % 16; end
                default: begin ok = 1; fpc = p; end
            endcase
        end
    endtask

    task automatic load_and_start(input bit combine);
        for (int a = 15; a >= 1; a--) begin
            @(negedge clk);
            imem_we = 1'b1; imem_waddr = 4'(a); imem_wdata = prog[a];
        end
        @(negedge clk);
        imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = prog[0]; start = combine;
        if (!combine) begin
            @(negedge clk);
            imem_we = 1'b0; start = 1'b1;
        end
        @(negedge clk);
        imem_we = 1'b0; start = 1'b0;
    endtask

    task automatic run_prog(input bit combine, input bit poke);
        int exp_cyc, exp_ret, exp_pc, cyc, nret;
        bit ok;
        load_and_start(combine);
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_pc", {28'd0, pc}, 32'd0);
        chk("start_cnt", {16'd0, retire_cnt}, 32'd0);
        model_run(exp_cyc, exp_ret, exp_pc, ok);
        chk("model_halts", {31'd0, ok}, 32'd1);
        cyc = 0; nret = 0;
        while (halted !== 1'b1 && cyc < 2000) begin
            imem_we    = poke && (cyc == 1);
            imem_waddr = 4'd3;
            imem_wdata = enc(0, 3, 0, 0, 'h77);
            start      = poke && (cyc == 3);
            @(negedge clk);
            cyc++;
            if (retire === 1'b1) nret++;
        end
        imem_we = 1'b0; start = 1'b0;
        last_cyc = cyc;
        chk("halt_reached", {31'd0, halted}, 32'd1);
        chk("halt_cycles", cyc, exp_cyc);
        chk("retire_pulses", nret, exp_ret);
        chk("retire_cnt", {16'd0, retire_cnt}, exp_ret);
        chk("halt_pc", {28'd0, pc}, exp_pc);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        for (int r = 0; r < 4; r++) chk_reg(r, ref_regs[r]);
        @(negedge clk);
        chk("retire_single", {31'd0, retire}, 32'd0);
    endtask

    initial begin
        int idx;
        rst_n = 1'b1; start = 1'b0; imem_we = 1'b0;
        imem_waddr = '0; imem_wdata = '0; dbg_rsel = '0;
        for (int r = 0; r < 4; r++) ref_regs[r] = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_cnt", {16'd0, retire_cnt}, 32'd0);
        chk("rst_pc", {28'd0, pc}, 32'd0);
        for (int r = 0; r < 4; r++) chk_reg(r, 8'd0);

        // Clear dmem with three store sweeps so later loads are predictable.
        for (int base = 0; base < 16; base += 7) begin
            fill_halt();
            prog[0] = enc(0, 0, 0, 0, 0);
            idx = 1;
            for (int k = base; k < base + 7 && k < 16; k++) begin
                prog[idx] = enc(0, 1, 0, 0, k);
                prog[idx + 1] = enc(5, 0, 1, 0, 0);
                idx += 2;
            end
            run_prog(1'b0, 1'b0);
        end

        fill_halt();
        prog[0] = enc(0, 1, 0, 0, 5);
        prog[1] = enc(0, 2, 0, 0, 3);
        prog[2] = enc(2, 3, 1, 2, 0);
        prog[3] = enc(5, 0, 2, 3, 0);
        prog[4] = enc(4, 0, 0, 2, 0);
        run_prog(1'b1, 1'b0);
        chk("plan_cycles", last_cyc, 32'd13);
        chk("plan_cnt", {16'd0, retire_cnt}, 32'd6);
        chk("plan_pc", {28'd0, pc}, 32'd5);
        chk_reg(3, 8'd8);
        chk_reg(0, 8'd8);

        fill_halt();
        prog[0] = enc(0, 1, 0, 0, 2);
        prog[1] = enc(0, 2, 0, 0, 3);
        prog[2] = enc(6, 3, 1, 2, 0);
        run_prog(1'b0, 1'b0);
        chk_reg(3, 8'hFF);

        for (int t = 0; t < 2; t++) begin
            fill_halt();
            prog[0] = enc(0, 0, 0, 0, t);
            prog[1] = enc(0, 1, 0, 0, 6);
            prog[2] = enc(3, 0, 0, 1, 0);
            prog[4] = enc(0, 2, 0, 0, 'hAA);
            prog[5] = enc(0, 2, 0, 0, 'hAB);
            run_prog(1'b0, 1'b0);
            chk("bz_pc", {28'd0, pc}, (t == 0) ? 32'd6 : 32'd3);
        end

        fill_halt();
        prog[0] = enc(0, 0, 0, 0, 0);
        prog[1] = enc(0, 1, 0, 0, 15);
        run_prog(1'b0, 1'b0);
        fill_halt();
        prog[0]  = enc(3, 0, 0, 1, 0);
        prog[15] = enc(0, 0, 0, 0, 1);
        run_prog(1'b0, 1'b0);
        chk("wrap_pc", {28'd0, pc}, 32'd1);
        chk_reg(0, 8'd1);

        fill_halt();
        prog[0] = enc(0, 1, 0, 0, 4);
        prog[1] = enc(0, 2, 0, 0, 'h55);
        prog[2] = enc(5, 0, 1, 2, 0);
        load_and_start(1'b0);
        repeat (5) @(negedge clk);
        chk("st_exec_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_retire", {31'd0, retire}, 32'd0);
        chk("midrst_pc", {28'd0, pc}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        for (int r = 0; r < 4; r++) ref_regs[r] = 8'd0;
        for (int r = 0; r < 4; r++) chk_reg(r, 8'd0);
        fill_halt();
        prog[0] = enc(0, 1, 0, 0, 4);
        prog[1] = enc(4, 0, 0, 1, 0);
        run_prog(1'b0, 1'b0);
        chk_reg(0, 8'd0);

        fill_halt();
        prog[0] = enc(0, 1, 0, 0, 7);
        prog[1] = enc(0, 2, 0, 0, 9);
        prog[2] = enc(2, 3, 1, 2, 0);
        run_prog(1'b0, 1'b1);
        chk_reg(3, 8'd16);
        fill_halt();
        run_prog(1'b0, 1'b0);
        chk_reg(3, 8'd16);

        for (int n = 0; n < 6; n++) begin
            int ops [6] = '{0, 1, 2, 4, 5, 6};
            for (int a = 0; a < 15; a++)
                prog[a] = enc(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                              $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 255));
            prog[15] = enc(7, 0, 0, 0, 0);
            run_prog(1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
